ahb_iopmp_loader: RTL



---
 rtl/ahb_enum.sv | 75 +++++++
 rtl/ahb_iopmp_loader_if.sv | 30 +++
 rtl/iopmp_cfg_table.sv | 29 ++
 rtl/ahb_iopmp_loader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ahb_enum.sv
// Shared AHB encodings plus the IOPMP loader register map, state enum and helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ahb_enum;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001
    } hburst_e;

    // Privileged data access, non-bufferable, non-cacheable.
    localparam logic [3:0] HPROT_PRIV_DATA = 4'b0011;

    // IOPMP config port register map, byte offsets from the port base.
    localparam logic [31:0] IOPMP_CTRL_OFS     = 32'h00;
    localparam logic [31:0] IOPMP_CTRL_STRIDE  = 32'h04;
    localparam logic [31:0] IOPMP_ENTRY_OFS    = 32'h10;
    localparam logic [31:0] IOPMP_PORT_STRIDE  = 32'h40;
    localparam logic [31:0] IOPMP_ENTRY_STRIDE = 32'h08;
    localparam logic [31:0] IOPMP_MASK_OFS     = 32'h04;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_DIS,
        LD_REG,
        LD_ENA,
        LD_DRAIN,
        LD_ERR
    } ld_state_e;

    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] base;
    } region_t;

    function automatic logic [31:0] iopmp_ctrl_ofs(input logic p);
        return IOPMP_CTRL_OFS + (p ? IOPMP_CTRL_STRIDE : 32'h0);
    endfunction

    function automatic logic [31:0] iopmp_base_ofs(input logic p, input logic [2:0] i);
        return IOPMP_ENTRY_OFS + (p ? IOPMP_PORT_STRIDE : 32'h0)
             + IOPMP_ENTRY_STRIDE * {29'b0, i};
    endfunction

    // Lowest enabled region index >= from; 8 means none left.
    function automatic logic [3:0] next_en(input logic [7:0] en, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (en[i] && (4'(i) >= from)) r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_iopmp_loader_if.sv
// AHB-lite master bus bundle used between the loader and the IOPMP config port.
// Latency: n/a (wiring only).
// Backpressure: slave stretches transfers with hready, reports faults on hresp.
interface ahb_iopmp_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import ahb_enum::*;

    logic [ADDR_WIDTH-1:0] haddr;
    htrans_e               htrans;
    logic                  hwrite;
    hsize_e                hsize;
    hburst_e               hburst;
    logic [3:0]            hprot;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    hresp_e                hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        input  hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        output hready, hresp
    );

endinterface

// File: rtl/iopmp_cfg_table.sv
// 8-entry region table {mask, base}: one synchronous write port, one combinational read port.
// Latency: write visible the cycle after we; read is same-cycle.
// Backpressure: none; writer gates we itself.
module iopmp_cfg_table
    import ahb_enum::*;
(
    input  logic       hclk,
    input  logic       hreset,
    input  logic       we,
    input  logic [2:0] wr_idx,
    input  region_t    wr_dat,
    input  logic [2:0] rd_idx,
    output region_t    rd_dat
);

    region_t mem [8];

    // Register file storage, cleared on reset.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/ahb_iopmp_loader.sv
// Programs an IOPMP port over AHB: disable CTRL, write BASE/MASK per enabled region, enable CTRL.
// Latency: first NONSEQ the cycle after start; done one cycle after the last data phase.
// Backpressure: all bus outputs hold while hready=0; ERROR response aborts and flags err.
module ahb_iopmp_loader
    import ahb_enum::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        tbl_we,
    input  logic [2:0]  tbl_idx,
    input  logic [31:0] tbl_base,
    input  logic [31:0] tbl_mask,
    input  logic        start,
    input  logic        port_sel,
    input  logic [7:0]  en,
    output logic        busy,
    output logic        done,
    output logic        err,
    ahb_iopmp_loader_if.master bus
);

    ld_state_e   state;
    logic [31:0] wdata_q;    // data for the transfer currently in its address phase
    logic [2:0]  idx;
    logic        half;       // 0: BASE of idx on the bus, 1: MASK of idx
    logic        psel;
    logic [7:0]  en_q;
    logic [3:0]  nxt_from;
    logic [3:0]  nxt;
    logic [2:0]  rd_idx;
    logic        data_phase;
    region_t     wr_dat;
    region_t     rd_dat;

    function automatic logic [ADDR_WIDTH-1:0] ctrl_addr(input logic p);
        return BASE_ADDR + ADDR_WIDTH'(iopmp_ctrl_ofs(p));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] base_addr(input logic p, input logic [2:0] i);
        return BASE_ADDR + ADDR_WIDTH'(iopmp_base_ofs(p, i));
    endfunction

    assign nxt_from   = (state == LD_DIS) ? 4'd0 : ({1'b0, idx} + 4'd1);
    assign nxt        = next_en(en_q, nxt_from);
    // MASK of the current region still pending, otherwise look ahead to the next region's BASE.
    assign rd_idx     = (state == LD_REG && !half) ? idx : nxt[2:0];
    // Every address phase after the first one overlaps the previous data phase.
    assign data_phase = (state != LD_DIS);
    assign wr_dat     = '{mask: tbl_mask, base: tbl_base};

    assign bus.hsize  = HSIZE_WORD;
    assign bus.hburst = HBURST_SINGLE;
    assign bus.hprot  = HPROT_PRIV_DATA;

    iopmp_cfg_table u_tbl (
        .hclk   (hclk),
        .hreset (hreset),
        .we     (tbl_we && (state == LD_IDLE)),
        .wr_idx (tbl_idx),
        .wr_dat (wr_dat),
        .rd_idx (rd_idx),
        .rd_dat (rd_dat)
    );

    // Sequencer: advances one pipelined transfer per hready-qualified cycle, registered bus outputs.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state      <= LD_IDLE;
            bus.haddr  <= BASE_ADDR;
            bus.htrans <= HTRANS_IDLE;
            bus.hwrite <= 1'b0;
            bus.hwdata <= '0;
            wdata_q    <= '0;
            idx        <= '0;
            half       <= 1'b0;
            psel       <= 1'b0;
            en_q       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LD_IDLE: begin
                    if (start) begin
                        state      <= LD_DIS;
                        psel       <= port_sel;
                        en_q       <= en;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        bus.haddr  <= ctrl_addr(port_sel);
                        bus.htrans <= HTRANS_NONSEQ;
                        bus.hwrite <= 1'b1;
                        wdata_q    <= '0;
                    end
                end
                LD_DIS, LD_REG, LD_ENA: begin
                    if (data_phase && !bus.hready && bus.hresp == HRESP_ERROR) begin
                        // Cancel the pending address phase; data phase finishes in LD_ERR.
                        state      <= LD_ERR;
                        bus.htrans <= HTRANS_IDLE;
                        bus.hwrite <= 1'b0;
                    end else if (bus.hready) begin
                        bus.hwdata <= DATA_WIDTH'(wdata_q);
                        if (state == LD_ENA) begin
                            state      <= LD_DRAIN;
                            bus.htrans <= HTRANS_IDLE;
                            bus.hwrite <= 1'b0;
                            bus.haddr  <= BASE_ADDR;
                        end else if (state == LD_REG && !half) begin
                            half      <= 1'b1;
                            bus.haddr <= bus.haddr + ADDR_WIDTH'(IOPMP_MASK_OFS);
                            wdata_q   <= rd_dat.mask;
                        end else if (nxt[3]) begin
                            state     <= LD_ENA;
                            bus.haddr <= ctrl_addr(psel);
                            wdata_q   <= {24'h0, en_q};
                        end else begin
                            state     <= LD_REG;
                            idx       <= nxt[2:0];
                            half      <= 1'b0;
                            bus.haddr <= base_addr(psel, nxt[2:0]);
                            wdata_q   <= rd_dat.base;
                        end
                    end
                end
                LD_DRAIN: begin
                    if (!bus.hready && bus.hresp == HRESP_ERROR) begin
                        state <= LD_ERR;
                    end else if (bus.hready) begin
                        state      <= LD_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        bus.hwdata <= '0;
                    end
                end
                LD_ERR: begin
                    if (bus.hready) begin
                        state      <= LD_IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        err        <= 1'b1;
                        bus.hwdata <= '0;
                        bus.haddr  <= BASE_ADDR;
                    end
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule
